// File: rtl/rv_pkg.sv
// Shared core types: register address and register-file write request payload.
package rv_pkg;

    localparam int unsigned RV_XLEN = 32;
    localparam int unsigned REG_AW  = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t            addr;
        logic [RV_XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_sync_fifo.sv
// Side-result FIFO; also exposes per-entry valid/addr for hazard lookup.
module sync_fifo
    import rv_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                          i_Clk,
    input  logic                          i_Reset,
    input  logic                          i_Push,
    input  wb_req_t                       i_Push_Data,
    input  logic                          i_Pop,
    output wb_req_t                       o_Head,
    output logic [PTR_W-1:0]              o_Head_Idx,
    output logic                          o_Full,
    output logic                          o_Empty,
    output logic [CNT_W-1:0]              o_Count,
    output logic [DEPTH-1:0]              o_Entry_Valid,
    output logic [DEPTH-1:0][REG_AW-1:0]  o_Entry_Addr
);

    wb_req_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [DEPTH-1:0]   entry_valid;

    // Payload storage; contents are qualified by entry_valid, so no reset.
    always_ff @(posedge i_Clk) begin
        if (i_Push) begin
            mem[wr_ptr] <= i_Push_Data;
        end
    end

    // Pointers, occupancy and per-entry valid bits.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (i_Push) begin
                wr_ptr              <= wr_ptr + PTR_W'(1);
                entry_valid[wr_ptr] <= 1'b1;
            end
            if (i_Pop) begin
                rd_ptr              <= rd_ptr + PTR_W'(1);
                entry_valid[rd_ptr] <= 1'b0;
            end
            case ({i_Push, i_Pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Address view of every slot for the pending comparators.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            o_Entry_Addr[i] = mem[i].addr;
        end
    end

    assign o_Head        = mem[rd_ptr];
    assign o_Head_Idx    = rd_ptr;
    assign o_Count       = count;
    assign o_Full        = (count == CNT_W'(DEPTH));
    assign o_Empty       = (count == '0);
    assign o_Entry_Valid = entry_valid;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter: WB has priority, side results queue until the port is free.
module regfile_write_arbiter
    import rv_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned XLEN  = 32,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_WB_Valid,
    input  logic [4:0]        i_WB_Addr,
    input  logic [XLEN-1:0]   i_WB_Data,
    input  logic              i_Side_Valid,
    input  logic [4:0]        i_Side_Addr,
    input  logic [XLEN-1:0]   i_Side_Data,
    output logic              o_Side_Ready,
    input  logic [4:0]        i_rAddr_1,
    input  logic [4:0]        i_rAddr_2,
    output logic              o_Pending_1,
    output logic              o_Pending_2,
    output logic              o_wEnable,
    output logic [4:0]        o_wAddr,
    output logic [XLEN-1:0]   o_wData,
    output logic [CNT_W-1:0]  o_Count
);

    logic                          side_fire;
    logic                          push;
    logic                          pop;
    logic                          wb_drive;
    logic                          full;
    logic                          empty;
    wb_req_t                       side_req;
    wb_req_t                       head;
    logic [PTR_W-1:0]              head_idx;
    logic [DEPTH-1:0]              entry_valid;
    logic [DEPTH-1:0][REG_AW-1:0]  entry_addr;

    // Handshake; x0 results complete the handshake but are dropped.
    assign o_Side_Ready  = ~full & ~i_Reset;
    assign side_fire     = i_Side_Valid & o_Side_Ready;
    assign push          = side_fire & (i_Side_Addr != '0);
    assign side_req.addr = i_Side_Addr;
    assign side_req.data = RV_XLEN'(i_Side_Data);

    // WB owns the port unless it targets x0; otherwise the FIFO head drains.
    assign wb_drive = i_WB_Valid & (i_WB_Addr != '0) & ~i_Reset;
    assign pop      = ~wb_drive & ~empty & ~i_Reset;

    sync_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_Push       (push),
        .i_Push_Data  (side_req),
        .i_Pop        (pop),
        .o_Head       (head),
        .o_Head_Idx   (head_idx),
        .o_Full       (full),
        .o_Empty      (empty),
        .o_Count      (o_Count),
        .o_Entry_Valid(entry_valid),
        .o_Entry_Addr (entry_addr)
    );

    // Write port priority mux.
    always_comb begin
        o_wEnable = 1'b0;
        o_wAddr   = '0;
        o_wData   = '0;
        if (wb_drive) begin
            o_wEnable = 1'b1;
            o_wAddr   = i_WB_Addr;
            o_wData   = i_WB_Data;
        end else if (pop) begin
            o_wEnable = 1'b1;
            o_wAddr   = head.addr;
            o_wData   = XLEN'(head.data);
        end
    end

    // Pending flags: queued-and-not-leaving entries plus the result entering this cycle.
    always_comb begin
        o_Pending_1 = push & (i_Side_Addr == i_rAddr_1);
        o_Pending_2 = push & (i_Side_Addr == i_rAddr_2);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (entry_valid[i] && !(pop && (head_idx == PTR_W'(i)))) begin
                if (entry_addr[i] == i_rAddr_1) o_Pending_1 = 1'b1;
                if (entry_addr[i] == i_rAddr_2) o_Pending_2 = 1'b1;
            end
        end
        if (i_rAddr_1 == '0 || i_Reset) o_Pending_1 = 1'b0;
        if (i_rAddr_2 == '0 || i_Reset) o_Pending_2 = 1'b0;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: queue-model scoreboard plus per-scenario checks.
module tb_regfile_write_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;

    logic              i_Clk;
    logic              i_Reset;
    logic              i_WB_Valid;
    logic [4:0]        i_WB_Addr;
    logic [XLEN-1:0]   i_WB_Data;
    logic              i_Side_Valid;
    logic [4:0]        i_Side_Addr;
    logic [XLEN-1:0]   i_Side_Data;
    logic              o_Side_Ready;
    logic [4:0]        i_rAddr_1;
    logic [4:0]        i_rAddr_2;
    logic              o_Pending_1;
    logic              o_Pending_2;
    logic              o_wEnable;
    logic [4:0]        o_wAddr;
    logic [XLEN-1:0]   o_wData;
    logic [2:0]        o_Count;

    regfile_write_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .i_Clk       (i_Clk),
        .i_Reset     (i_Reset),
        .i_WB_Valid  (i_WB_Valid),
        .i_WB_Addr   (i_WB_Addr),
        .i_WB_Data   (i_WB_Data),
        .i_Side_Valid(i_Side_Valid),
        .i_Side_Addr (i_Side_Addr),
        .i_Side_Data (i_Side_Data),
        .o_Side_Ready(o_Side_Ready),
        .i_rAddr_1   (i_rAddr_1),
        .i_rAddr_2   (i_rAddr_2),
        .o_Pending_1 (o_Pending_1),
        .o_Pending_2 (o_Pending_2),
        .o_wEnable   (o_wEnable),
        .o_wAddr     (o_wAddr),
        .o_wData     (o_wData),
        .o_Count     (o_Count)
    );

    typedef struct {
        logic [4:0]       addr;
        logic [XLEN-1:0]  data;
    } ent_t;

    ent_t model_q[$];
    int   total = 0;
    int   bad   = 0;

    logic             mon_en;
    logic [4:0]       mon_addr;
    logic [XLEN-1:0]  mon_data;
    logic             mon_rdy;
    int               mon_cnt;
    ent_t             mon_e;

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Scoreboard: model queue predicts port, occupancy and ready every cycle.
    always @(negedge i_Clk) begin
        if (i_Reset) begin
            model_q.delete();
            mon_en = 1'b0; mon_addr = '0; mon_data = '0; mon_rdy = 1'b0; mon_cnt = 0;
        end else begin
            mon_rdy = (model_q.size() < DEPTH);
            mon_cnt = model_q.size();
            if (i_WB_Valid && i_WB_Addr != 5'd0) begin
                foreach (model_q[k])
                    assert (model_q[k].addr != i_WB_Addr) else $error("WAW stimulus on x%0d", i_WB_Addr);
                mon_en = 1'b1; mon_addr = i_WB_Addr; mon_data = i_WB_Data;
            end else if (model_q.size() > 0) begin
                mon_e = model_q.pop_front();
                mon_en = 1'b1; mon_addr = mon_e.addr; mon_data = mon_e.data;
            end else begin
                mon_en = 1'b0; mon_addr = '0; mon_data = '0;
            end
            if (i_Side_Valid && mon_rdy && i_Side_Addr != 5'd0) begin
                mon_e.addr = i_Side_Addr; mon_e.data = i_Side_Data;
                model_q.push_back(mon_e);
            end
        end
        total++;
        if (o_wEnable !== mon_en || o_wAddr !== mon_addr || o_wData !== mon_data) begin
            bad++;
            $display("FAIL sb_port @%0t: got en=%0b a=%0d d=%h want en=%0b a=%0d d=%h",
                     $time, o_wEnable, o_wAddr, o_wData, mon_en, mon_addr, mon_data);
        end
        total++;
        if (o_Count !== 3'(mon_cnt) || o_Side_Ready !== mon_rdy) begin
            bad++;
            $display("FAIL sb_count @%0t: got cnt=%0d rdy=%0b want cnt=%0d rdy=%0b",
                     $time, o_Count, o_Side_Ready, mon_cnt, mon_rdy);
        end
    end

    task automatic step;
        @(posedge i_Clk);
        #1;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] a, input logic [XLEN-1:0] d);
        i_WB_Valid = v; i_WB_Addr = a; i_WB_Data = d;
    endtask

    task automatic set_side(input logic v, input logic [4:0] a, input logic [XLEN-1:0] d);
        i_Side_Valid = v; i_Side_Addr = a; i_Side_Data = d;
    endtask

    task automatic wait_drain;
        for (int n = 0; n < 20; n++) begin
            @(negedge i_Clk);
            if (o_Count == 3'd0) break;
            step();
        end
        total++;
        if (o_Count !== 3'd0) begin
            bad++;
            $display("FAIL drain_timeout: got cnt=%0d want 0", o_Count);
        end
        step();
    endtask

    task automatic test_reset;
        i_Reset = 1'b1;
        set_wb(1'b0, 5'd0, '0);
        set_side(1'b0, 5'd0, '0);
        i_rAddr_1 = 5'd0; i_rAddr_2 = 5'd0;
        repeat (2) @(posedge i_Clk);
        @(negedge i_Clk);
        total++;
        if (o_Side_Ready !== 1'b0 || o_Count !== 3'd0 || o_wEnable !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got rdy=%0b cnt=%0d en=%0b want 0 0 0", o_Side_Ready, o_Count, o_wEnable);
        end
        step();
        i_Reset = 1'b0;
        @(negedge i_Clk);
        total++;
        if (o_Side_Ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %0b want 1", o_Side_Ready);
        end
        step();
    endtask

    task automatic test_single_side;
        set_side(1'b1, 5'd5, 32'hA5);
        @(negedge i_Clk);
        total++;
        if (o_wEnable !== 1'b0 || o_Count !== 3'd0) begin
            bad++;
            $display("FAIL single_push_cycle: got en=%0b cnt=%0d want 0 0", o_wEnable, o_Count);
        end
        step();
        set_side(1'b0, 5'd0, '0);
        @(negedge i_Clk);
        total++;
        if (o_wEnable !== 1'b1 || o_wAddr !== 5'd5 || o_wData !== 32'hA5 || o_Count !== 3'd1) begin
            bad++;
            $display("FAIL single_write: got en=%0b a=%0d d=%h cnt=%0d want 1 5 a5 1", o_wEnable, o_wAddr, o_wData, o_Count);
        end
        step();
        @(negedge i_Clk);
        total++;
        if (o_Count !== 3'd0 || o_wEnable !== 1'b0) begin
            bad++;
            $display("FAIL single_after: got cnt=%0d en=%0b want 0 0", o_Count, o_wEnable);
        end
        step();
    endtask

    task automatic test_starvation;
        set_wb(1'b1, 5'd3, 32'h11);
        for (int k = 0; k < 4; k++) begin
            set_side(1'b1, 5'(10 + k), 32'h100 + k);
            @(negedge i_Clk);
            total++;
            if (o_wAddr !== 5'd3 || o_wData !== 32'h11) begin
                bad++;
                $display("FAIL starve_port: got a=%0d d=%h want 3 11", o_wAddr, o_wData);
            end
            step();
        end
        set_side(1'b0, 5'd0, '0);
        @(negedge i_Clk);
        total++;
        if (o_Count !== 3'd4 || o_Side_Ready !== 1'b0 || o_wAddr !== 5'd3) begin
            bad++;
            $display("FAIL starve_full: got cnt=%0d rdy=%0b a=%0d want 4 0 3", o_Count, o_Side_Ready, o_wAddr);
        end
        step();
        set_wb(1'b0, 5'd0, '0);
        @(negedge i_Clk);
        total++;
        if (o_wAddr !== 5'd10 || o_wData !== 32'h100) begin
            bad++;
            $display("FAIL starve_first_drain: got a=%0d d=%h want 10 100", o_wAddr, o_wData);
        end
        step();
        wait_drain();
    endtask

    task automatic test_pending;
        i_rAddr_1 = 5'd7; i_rAddr_2 = 5'd8;
        set_side(1'b1, 5'd7, 32'h77);
        @(negedge i_Clk);
        total++;
        if (o_Pending_1 !== 1'b1 || o_Pending_2 !== 1'b0) begin
            bad++;
            $display("FAIL pend_push: got p1=%0b p2=%0b want 1 0", o_Pending_1, o_Pending_2);
        end
        step();
        set_side(1'b0, 5'd0, '0);
        set_wb(1'b1, 5'd3, 32'h33);
        @(negedge i_Clk);
        total++;
        if (o_Pending_1 !== 1'b1) begin
            bad++;
            $display("FAIL pend_queued: got %0b want 1", o_Pending_1);
        end
        step();
        set_wb(1'b0, 5'd0, '0);
        @(negedge i_Clk);
        total++;
        if (o_Pending_1 !== 1'b0 || o_wAddr !== 5'd7) begin
            bad++;
            $display("FAIL pend_drain: got p1=%0b a=%0d want 0 7", o_Pending_1, o_wAddr);
        end
        step();
    endtask

    task automatic test_x0;
        set_wb(1'b1, 5'd3, 32'h33);
        set_side(1'b1, 5'd9, 32'h99);
        step();
        set_side(1'b0, 5'd0, '0);
        set_wb(1'b1, 5'd0, 32'h55);
        @(negedge i_Clk);
        total++;
        if (o_wEnable !== 1'b1 || o_wAddr !== 5'd9 || o_wData !== 32'h99) begin
            bad++;
            $display("FAIL wb_x0_drain: got en=%0b a=%0d d=%h want 1 9 99", o_wEnable, o_wAddr, o_wData);
        end
        step();
        set_wb(1'b0, 5'd0, '0);
        set_side(1'b1, 5'd0, 32'hDEAD);
        i_rAddr_1 = 5'd0;
        @(negedge i_Clk);
        total++;
        if (o_Side_Ready !== 1'b1 || o_Pending_1 !== 1'b0 || o_wEnable !== 1'b0) begin
            bad++;
            $display("FAIL side_x0_fire: got rdy=%0b p1=%0b en=%0b want 1 0 0", o_Side_Ready, o_Pending_1, o_wEnable);
        end
        step();
        set_side(1'b0, 5'd0, '0);
        @(negedge i_Clk);
        total++;
        if (o_Count !== 3'd0 || o_wEnable !== 1'b0) begin
            bad++;
            $display("FAIL side_x0_drop: got cnt=%0d en=%0b want 0 0", o_Count, o_wEnable);
        end
        step();
    endtask

    task automatic test_push_pop;
        set_wb(1'b1, 5'd3, 32'h33);
        for (int k = 0; k < 3; k++) begin
            set_side(1'b1, 5'(21 + k), 32'h200 + k);
            step();
        end
        set_wb(1'b0, 5'd0, '0);
        set_side(1'b1, 5'd24, 32'h224);
        @(negedge i_Clk);
        total++;
        if (o_Count !== 3'd3 || o_wAddr !== 5'd21) begin
            bad++;
            $display("FAIL pp_simul: got cnt=%0d a=%0d want 3 21", o_Count, o_wAddr);
        end
        step();
        set_wb(1'b1, 5'd3, 32'h33);
        set_side(1'b1, 5'd25, 32'h225);
        @(negedge i_Clk);
        total++;
        if (o_Count !== 3'd3) begin
            bad++;
            $display("FAIL pp_hold: got cnt=%0d want 3", o_Count);
        end
        step();
        set_wb(1'b0, 5'd0, '0);
        set_side(1'b1, 5'd26, 32'h226);
        @(negedge i_Clk);
        total++;
        if (o_Count !== 3'd4 || o_Side_Ready !== 1'b0) begin
            bad++;
            $display("FAIL pp_full_pop: got cnt=%0d rdy=%0b want 4 0", o_Count, o_Side_Ready);
        end
        step();
        @(negedge i_Clk);
        total++;
        if (o_Count !== 3'd3 || o_Side_Ready !== 1'b1) begin
            bad++;
            $display("FAIL pp_no_credit: got cnt=%0d rdy=%0b want 3 1", o_Count, o_Side_Ready);
        end
        step();
        set_side(1'b0, 5'd0, '0);
        @(negedge i_Clk);
        total++;
        if (o_Count !== 3'd3) begin
            bad++;
            $display("FAIL pp_after: got cnt=%0d want 3", o_Count);
        end
        step();
        wait_drain();
    endtask

    task automatic test_back_to_back;
        set_wb(1'b0, 5'd0, '0);
        for (int k = 0; k < 10; k++) begin
            set_side(1'b1, 5'(1 + k), $urandom());
            step();
        end
        set_side(1'b0, 5'd0, '0);
        wait_drain();
    endtask

    task automatic test_reset_mid;
        i_rAddr_1 = 5'd11;
        set_wb(1'b1, 5'd3, 32'h33);
        for (int k = 0; k < 3; k++) begin
            set_side(1'b1, 5'(11 + k), 32'h300 + k);
            step();
        end
        set_side(1'b0, 5'd0, '0);
        i_Reset = 1'b1;
        #1;
        total++;
        if (o_wEnable !== 1'b0 || o_wAddr !== 5'd0 || o_wData !== '0 || o_Count !== 3'd0
            || o_Side_Ready !== 1'b0 || o_Pending_1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got en=%0b a=%0d d=%h cnt=%0d rdy=%0b p1=%0b want all 0",
                     o_wEnable, o_wAddr, o_wData, o_Count, o_Side_Ready, o_Pending_1);
        end
        set_wb(1'b0, 5'd0, '0);
        step();
        i_Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_Clk);
            total++;
            if (o_wEnable !== 1'b0 || o_Count !== 3'd0 || o_Pending_1 !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_stale: got en=%0b a=%0d cnt=%0d p1=%0b want 0 - 0 0",
                         o_wEnable, o_wAddr, o_Count, o_Pending_1);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single_side();
        test_starvation();
        test_pending();
        test_x0();
        test_push_pop();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
